multi_clk_div: RTL and testbench
================================

# multi_clk_div

Multi-channel integer clock divider: parametrised successor of the single-channel `CLK_DIV`. It derives NUM_CH divided clocks from one reference clock. Each channel has its own enable and ratio, applies ratio and enable changes glitch-free only at period boundaries, and exposes a per-period tick and an update-acknowledge pulse. It sits in the clock-generation area, feeding UART and other slow-domain clocks.

## Interface
- NUM_CH, 2, number of independent divider channels (1..8)
- RATIO_W, 8, width of each channel's division ratio
- i_ref_clk  input  1  reference clock; all state is posedge-clocked, except the optional negedge flop
- i_rst  input  1  asynchronous, active-high reset
- i_clk_en  input  NUM_CH  per-channel enable
- i_div_ratio  input  NUM_CH*RATIO_W  packed ratios; channel k occupies bits [k*RATIO_W +: RATIO_W]
- o_div_clk  output  NUM_CH  divided clock, or i_ref_clk in bypass
- o_div_tick  output  NUM_CH  one-ref-cycle pulse at each divided-clock rising edge
- o_upd_done  output  NUM_CH  one-ref-cycle pulse when a new active ratio or mode takes effect

## Operation
**Channel states:**
- BYPASS: o_div_clk = i_ref_clk.
- RUN: o_div_clk = div_q.

**Channel registers:**
- cnt, RATIO_W bits.
- r_act: active ratio.
- div_q.
- state.

**Run condition:** en_ok = i_clk_en[k] && ratio ≥ 2. Ratios 0 and 1 mean bypass.

**BYPASS → RUN:**
- At any posedge with en_ok.
- Load r_act = ratio, set cnt = 0, div_q = 1, pulse o_upd_done.

**Counting in RUN:**
- cnt increments each posedge and wraps to 0 after r_act-1.
- div_q = (next_cnt < H), where H = r_act>>1 (floor).
- N=2 gives 1 high / 1 low; N=3 gives 1 high / 2 low; N=4 gives 2 high / 2 low.

**At wrap (cnt == r_act-1), the next state is decided:**
- !en_ok → BYPASS. Pulse o_upd_done.
- en_ok and ratio ≠ r_act → load the new r_act, cnt = 0, pulse o_upd_done.
- Otherwise continue with the same ratio.

**Mid-period changes:** changes to i_clk_en or i_div_ratio mid-period are ignored until the wrap. No runt pulses are produced.

**o_div_tick:** registered. High for the ref cycle in which cnt == 0 in RUN. Never asserted in BYPASS.

**Glitch-free mode switch:** all state changes occur at a posedge where div_q becomes 1 and i_ref_clk is high. The output stays high across every switch.

**Channel independence:** channels are fully independent and need not stay in phase with each other.

## Timing
**Reset (asynchronous, immediate, also mid-operation):**
- state = BYPASS, cnt = 0, r_act = 0, div_q = 0.
- o_div_tick = 0, o_upd_done = 0.
- o_div_clk = i_ref_clk.

**Enable latency:** the first divided rising edge coincides with the first posedge that samples en_ok. o_upd_done and o_div_tick are high for that same ref cycle.

**Ratio change latency:** the new ratio takes effect at the first wrap after it is presented. The worst case is old r_act ref cycles.

**Simultaneous disable and ratio change at a wrap:** disable wins. o_upd_done pulses once.

**o_div_tick and o_upd_done:** exactly one ref cycle wide. Both are registered on i_ref_clk.

**Ratio = 2^RATIO_W-1:** cnt must not overflow. It is compared against r_act-1 at full width.

## Configuration
Macro `MULTI_CLK_DIV_DUTY50_EN`.

**Defined:**
- Each channel adds a negedge flop div_n that samples div_q.
- For odd r_act in RUN, o_div_clk = div_q | div_n, giving a high time of H+0.5 ref cycles (exact 50% duty).
- Even ratios and BYPASS are unaffected.
- div_n resets to 0.

**Undefined:**
- No negedge logic.
- Odd ratios give a high time of floor(N/2) cycles.

## Structure
**`multi_clk_div_pkg`:**
- State enum (BYPASS, RUN).
- Default RATIO_W.
- Function hi_len(ratio) returning ratio>>1.
- Function ratio_ok(ratio) returning ratio ≥ 2.

**`clk_div_ch` sub-module:**
- One channel: counter, state machine, div_q, tick, upd_done and the optional negedge flop.
- `multi_clk_div` is a generate loop of NUM_CH instances plus ratio-bus slicing.

## Test plan
- Reset asserted with i_clk_en = 0 → o_div_clk tracks i_ref_clk. Tick and upd_done are 0 for 5 ref cycles.
- Channel 0: enable with ratio 4 → period 40 ns on a 10 ns ref clock, 20 ns high. upd_done pulses once. Tick every 4 cycles.
- Ratio changed 4→3 mid-period → the current 4-cycle period completes, then a 3-cycle period. High is 10 ns without the macro and 15 ns with `MULTI_CLK_DIV_DUTY50_EN`.
- Ratio changed to 1, then to 0, while enabled → the channel enters BYPASS at the next wrap. No output pulse shorter than 5 ns.
- NUM_CH = 2 with ratios 2 and 5 running concurrently; channel 1 disabled mid-period → channel 0 is unaffected, and channel 1 enters BYPASS at its wrap.
- i_rst asserted mid-period with ratio 5 → all outputs reach their reset values immediately. After release, the channel restarts with cnt = 0 at the first posedge with en_ok.

Source files
------------

// File: rtl/multi_clk_div_pkg.sv
// Shared types and helpers for the multi-channel integer clock divider.
// Optional feature macro: MULTI_CLK_DIV_DUTY50_EN (see clk_div_ch).
package multi_clk_div_pkg;

  typedef enum logic {
    ST_BYPASS = 1'b0,
    ST_RUN    = 1'b1
  } ch_state_t;

  localparam int DEF_RATIO_W = 8;
  // Helpers work on a fixed wide ratio so any RATIO_W up to 32 can use them.
  localparam int RATIO_EXT_W = 32;

  function automatic logic [RATIO_EXT_W-1:0] hi_len(input logic [RATIO_EXT_W-1:0] ratio);
    return ratio >> 1;
  endfunction

  function automatic logic ratio_ok(input logic [RATIO_EXT_W-1:0] ratio);
    return ratio >= RATIO_EXT_W'(2);
  endfunction

endpackage

// File: rtl/multi_clk_div_if.sv
// Per-channel enable/ratio inputs and divided-clock/tick/ack outputs of multi_clk_div.
interface multi_clk_div_if #(
  parameter int NUM_CH  = 2,
  parameter int RATIO_W = 8
);
  logic [NUM_CH-1:0]         i_clk_en;
  logic [NUM_CH*RATIO_W-1:0] i_div_ratio;
  logic [NUM_CH-1:0]         o_div_clk;
  logic [NUM_CH-1:0]         o_div_tick;
  logic [NUM_CH-1:0]         o_upd_done;

  modport master (
    output i_clk_en, i_div_ratio,
    input  o_div_clk, o_div_tick, o_upd_done
  );

  modport slave (
    input  i_clk_en, i_div_ratio,
    output o_div_clk, o_div_tick, o_upd_done
  );
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, BYPASS/RUN state machine, tick and update-ack pulses.
// With MULTI_CLK_DIV_DUTY50_EN a negedge flop stretches odd-ratio high time by half a cycle.
//
// state     | meaning
// ST_BYPASS | output follows i_ref_clk; waits for enable with ratio >= 2
// ST_RUN    | output is the divided clock; ratio/enable sampled only at wrap
module clk_div_ch
  import multi_clk_div_pkg::*;
#(
  parameter int RATIO_W = DEF_RATIO_W
) (
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic               i_clk_en,
  input  logic [RATIO_W-1:0] i_ratio,
  output logic               o_div_clk,
  output logic               o_div_tick,
  output logic               o_upd_done
);

  ch_state_t          r_state, w_state_n;
  logic [RATIO_W-1:0] r_cnt, w_cnt_n;
  logic [RATIO_W-1:0] r_act, w_act_n;
  logic               r_div_q, w_div_q_n;
  logic               r_tick, w_tick_n;
  logic               r_upd, w_upd_n;

  logic               w_en_ok;
  logic               w_wrap;
  logic [RATIO_W-1:0] w_last;
  logic [RATIO_W-1:0] w_cnt_inc;
  logic [RATIO_W-1:0] w_hi;
  logic               w_run_clk;

  assign w_en_ok   = i_clk_en && ratio_ok(RATIO_EXT_W'(i_ratio));
  // Full-width compare keeps a ratio of 2^RATIO_W-1 from overflowing cnt.
  assign w_last    = r_act - RATIO_W'(1);
  assign w_wrap    = (r_cnt == w_last);
  assign w_cnt_inc = r_cnt + RATIO_W'(1);
  assign w_hi      = RATIO_W'(hi_len(RATIO_EXT_W'(r_act)));

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_BYPASS;
      r_cnt   <= '0;
      r_act   <= '0;
      r_div_q <= 1'b0;
      r_tick  <= 1'b0;
      r_upd   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_act   <= w_act_n;
      r_div_q <= w_div_q_n;
      r_tick  <= w_tick_n;
      r_upd   <= w_upd_n;
    end
  end

  // Every transition lands on a posedge where the output is, or becomes, high.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_act_n   = r_act;
    w_div_q_n = r_div_q;
    w_tick_n  = 1'b0;
    w_upd_n   = 1'b0;
    case (r_state)
      ST_BYPASS: begin
        if (w_en_ok) begin
          w_state_n = ST_RUN;
          w_act_n   = i_ratio;
          w_cnt_n   = '0;
          w_div_q_n = 1'b1;
          w_tick_n  = 1'b1;
          w_upd_n   = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_wrap) begin
          w_cnt_n = '0;
          if (!w_en_ok) begin
            w_state_n = ST_BYPASS;
            w_div_q_n = 1'b0;
            w_upd_n   = 1'b1;
          end else begin
            w_div_q_n = 1'b1;
            w_tick_n  = 1'b1;
            if (i_ratio != r_act) begin
              w_act_n = i_ratio;
              w_upd_n = 1'b1;
            end
          end
        end else begin
          w_cnt_n   = w_cnt_inc;
          w_div_q_n = (w_cnt_inc < w_hi);
        end
      end
      default: begin
        w_state_n = ST_BYPASS;
      end
    endcase
  end

`ifdef MULTI_CLK_DIV_DUTY50_EN
  logic r_div_n;

  always_ff @(negedge i_ref_clk or posedge i_rst) begin
    if (i_rst) r_div_n <= 1'b0;
    else       r_div_n <= r_div_q;
  end

  assign w_run_clk = r_act[0] ? (r_div_q | r_div_n) : r_div_q;
`else
  assign w_run_clk = r_div_q;
`endif

  assign o_div_clk  = (r_state == ST_RUN) ? w_run_clk : i_ref_clk;
  assign o_div_tick = r_tick;
  assign o_upd_done = r_upd;

endmodule

// File: rtl/multi_clk_div.sv
// NUM_CH independent integer clock dividers sharing one reference clock and reset.
// Optional feature macro: MULTI_CLK_DIV_DUTY50_EN (50% duty for odd ratios).
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int RATIO_W = DEF_RATIO_W
) (
  input  logic            i_ref_clk,
  input  logic            i_rst,
  multi_clk_div_if.slave  bus
);

  logic [NUM_CH-1:0]         w_clk_en;
  logic [NUM_CH*RATIO_W-1:0] w_ratio;
  logic [NUM_CH-1:0]         w_div_clk;
  logic [NUM_CH-1:0]         w_div_tick;
  logic [NUM_CH-1:0]         w_upd_done;

  assign w_clk_en = bus.i_clk_en;
  assign w_ratio  = bus.i_div_ratio;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_ch #(
      .RATIO_W (RATIO_W)
    ) u_ch (
      .i_ref_clk  (i_ref_clk),
      .i_rst      (i_rst),
      .i_clk_en   (w_clk_en[k]),
      .i_ratio    (w_ratio[k*RATIO_W +: RATIO_W]),
      .o_div_clk  (w_div_clk[k]),
      .o_div_tick (w_div_tick[k]),
      .o_upd_done (w_upd_done[k])
    );
  end

  assign bus.o_div_clk  = w_div_clk;
  assign bus.o_div_tick = w_div_tick;
  assign bus.o_upd_done = w_upd_done;

endmodule

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div (default build, 50% duty option off).
module tb_multi_clk_div;
  localparam int NCH = 2;
  localparam int RW  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_clk_div_if #(.NUM_CH(NCH), .RATIO_W(RW)) bus ();

  multi_clk_div #(.NUM_CH(NCH), .RATIO_W(RW)) dut (
    .i_ref_clk (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step_pos();
    @(posedge clk); #1;
  endtask

  task automatic step_neg();
    @(negedge clk); #1;
  endtask

  task automatic set_ratio(input int ch, input int r);
    bus.i_div_ratio[ch*RW +: RW] = RW'(r);
  endtask

  task automatic do_reset();
    bus.i_clk_en = '0;
    rst = 1'b1;
    step_pos();
    step_neg();
    rst = 1'b0;
  endtask

  typedef struct {
    int ratio;
    int exp_hi;
    int exp_period;
  } vec_t;
  vec_t vecs[6];

  // Reference model: per channel, position within the current period.
  bit m_run[NCH];
  int m_n[NCH];
  int m_ph[NCH];
  bit e_tick[NCH];
  bit e_upd[NCH];

  task automatic model_posedge();
    for (int k = 0; k < NCH; k++) begin
      int r;
      bit ok;
      r  = int'(bus.i_div_ratio[k*RW +: RW]);
      ok = bus.i_clk_en[k] && (r >= 2);
      e_tick[k] = 1'b0;
      e_upd[k]  = 1'b0;
      if (!m_run[k]) begin
        if (ok) begin
          m_run[k] = 1'b1; m_n[k] = r; m_ph[k] = 0;
          e_tick[k] = 1'b1; e_upd[k] = 1'b1;
        end
      end else if (m_ph[k] == m_n[k] - 1) begin
        if (!ok) begin
          m_run[k] = 1'b0; e_upd[k] = 1'b1;
        end else begin
          e_upd[k] = (r != m_n[k]);
          m_n[k] = r; m_ph[k] = 0; e_tick[k] = 1'b1;
        end
      end else begin
        m_ph[k]++;
      end
    end
  endtask

  function automatic bit model_clk(input int k, input bit ref_hi);
    if (!m_run[k]) return ref_hi;
    return m_ph[k] < (m_n[k] / 2);
  endfunction

  initial begin
    int hi, mid_t, mid_u;
    vecs[0] = '{2, 1, 2};
    vecs[1] = '{3, 1, 3};
    vecs[2] = '{4, 2, 4};
    vecs[3] = '{5, 2, 5};
    vecs[4] = '{8, 4, 8};
    vecs[5] = '{255, 127, 255};

    rst = 1'b1;
    bus.i_clk_en = '0;
    bus.i_div_ratio = '0;

    // Reset held: outputs follow the reference, no pulses.
    for (int c = 0; c < 5; c++) begin
      step_pos();
      chk("rst_clk_hi", int'(bus.o_div_clk), 3);
      chk("rst_tick", int'(bus.o_div_tick), 0);
      chk("rst_upd", int'(bus.o_upd_done), 0);
      step_neg();
      chk("rst_clk_lo", int'(bus.o_div_clk), 0);
    end

    // Table: one full period per ratio on channel 0.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      set_ratio(0, vecs[v].ratio);
      bus.i_clk_en[0] = 1'b1;
      step_pos();
      chk("vec_first_upd", int'(bus.o_upd_done[0]), 1);
      chk("vec_first_tick", int'(bus.o_div_tick[0]), 1);
      chk("vec_first_clk", int'(bus.o_div_clk[0]), 1);
      hi = 1; mid_t = 0; mid_u = 0;
      for (int c = 1; c < vecs[v].exp_period; c++) begin
        step_pos();
        hi    += int'(bus.o_div_clk[0]);
        mid_t += int'(bus.o_div_tick[0]);
        mid_u += int'(bus.o_upd_done[0]);
      end
      step_pos();
      chk("vec_period_tick", int'(bus.o_div_tick[0]), 1);
      chk("vec_period_upd", int'(bus.o_upd_done[0]), 0);
      chk("vec_hi_cycles", hi, vecs[v].exp_hi);
      chk("vec_mid_tick", mid_t, 0);
      chk("vec_mid_upd", mid_u, 0);
      step_neg();
    end

    // Ratio 4 -> 3 mid-period: old period completes, then 3-cycle period.
    do_reset();
    set_ratio(0, 4);
    bus.i_clk_en[0] = 1'b1;
    step_pos();
    step_pos();
    set_ratio(0, 3);
    step_pos();
    chk("a_mid_upd", int'(bus.o_upd_done[0]), 0);
    step_pos();
    chk("a_old_low", int'(bus.o_div_clk[0]), 0);
    step_pos();
    chk("a_new_upd", int'(bus.o_upd_done[0]), 1);
    chk("a_new_tick", int'(bus.o_div_tick[0]), 1);
    step_neg();
    chk("a_hi_first_cycle", int'(bus.o_div_clk[0]), 1);
    step_pos();
    chk("a_hi10", int'(bus.o_div_clk[0]), 0);
    chk("a_tick_off", int'(bus.o_div_tick[0]), 0);
    step_pos();
    step_pos();
    chk("a_period3_tick", int'(bus.o_div_tick[0]), 1);
    chk("a_period3_upd", int'(bus.o_upd_done[0]), 0);

    // Ratio -> 1 then 0 while enabled: bypass at next wrap.
    do_reset();
    set_ratio(0, 4);
    bus.i_clk_en[0] = 1'b1;
    step_pos();
    step_pos();
    set_ratio(0, 1);
    step_pos();
    step_pos();
    chk("b_still_run", int'(bus.o_div_clk[0]), 0);
    step_pos();
    chk("b_bypass_upd", int'(bus.o_upd_done[0]), 1);
    chk("b_bypass_tick", int'(bus.o_div_tick[0]), 0);
    chk("b_bypass_hi", int'(bus.o_div_clk[0]), 1);
    step_neg();
    chk("b_bypass_lo", int'(bus.o_div_clk[0]), 0);
    set_ratio(0, 0);
    for (int c = 0; c < 3; c++) begin
      step_pos();
      chk("b_stay_upd", int'(bus.o_upd_done[0]), 0);
      chk("b_stay_tick", int'(bus.o_div_tick[0]), 0);
    end

    // Two channels, ratios 2 and 5; ch1 disabled plus ratio change mid-period.
    do_reset();
    set_ratio(0, 2);
    set_ratio(1, 5);
    bus.i_clk_en = 2'b11;
    step_pos();
    chk("c_start_upd", int'(bus.o_upd_done), 3);
    chk("c_start_tick", int'(bus.o_div_tick), 3);
    step_pos();
    bus.i_clk_en[1] = 1'b0;
    set_ratio(1, 3);
    for (int p = 2; p < 9; p++) begin
      step_pos();
      chk("c_ch0_tick", int'(bus.o_div_tick[0]), (p % 2 == 0) ? 1 : 0);
      chk("c_ch0_clk", int'(bus.o_div_clk[0]), (p % 2 == 0) ? 1 : 0);
      chk("c_ch0_upd", int'(bus.o_upd_done[0]), 0);
      chk("c_ch1_upd", int'(bus.o_upd_done[1]), (p == 5) ? 1 : 0);
      chk("c_ch1_tick", int'(bus.o_div_tick[1]), 0);
      step_neg();
      if (p >= 5) chk("c_ch1_bypass_lo", int'(bus.o_div_clk[1]), 0);
      else        chk("c_ch1_run_lo", int'(bus.o_div_clk[1]), 0);
    end

    // Reset mid-period with ratio 5, then restart.
    do_reset();
    set_ratio(0, 5);
    bus.i_clk_en[0] = 1'b1;
    step_pos();
    step_pos();
    step_pos();
    chk("d_pre_low", int'(bus.o_div_clk[0]), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("d_rst_clk", int'(bus.o_div_clk[0]), 1);
    chk("d_rst_tick", int'(bus.o_div_tick[0]), 0);
    chk("d_rst_upd", int'(bus.o_upd_done[0]), 0);
    step_neg();
    chk("d_rst_clk_lo", int'(bus.o_div_clk[0]), 0);
    rst = 1'b0;
    step_pos();
    chk("d_restart_upd", int'(bus.o_upd_done[0]), 1);
    chk("d_restart_tick", int'(bus.o_div_tick[0]), 1);
    chk("d_restart_clk", int'(bus.o_div_clk[0]), 1);
    step_neg();

    // Randomized traffic on both channels against the period model.
    do_reset();
    for (int k = 0; k < NCH; k++) begin
      m_run[k] = 1'b0; m_n[k] = 0; m_ph[k] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          int r;
          bus.i_clk_en[k] = ($urandom_range(0, 3) != 0);
          r = int'($urandom_range(0, 15));
          if (r >= 12) r = int'($urandom_range(12, 40));
          set_ratio(k, r);
        end
      end
      step_pos();
      model_posedge();
      for (int k = 0; k < NCH; k++) begin
        chk("r_clk_hi", int'(bus.o_div_clk[k]), int'(model_clk(k, 1'b1)));
        chk("r_tick", int'(bus.o_div_tick[k]), int'(e_tick[k]));
        chk("r_upd", int'(bus.o_upd_done[k]), int'(e_upd[k]));
      end
      step_neg();
      for (int k = 0; k < NCH; k++)
        chk("r_clk_lo", int'(bus.o_div_clk[k]), int'(model_clk(k, 1'b0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
